voice_scheduler: RTL and testbench
==================================

// Module: voice_scheduler
// PURPOSE
//   Time-multiplexed sequencer for the audio path. Shares one phase adder and one
//   multiplier among NUM_VOICES sawtooth voices and sums their scaled outputs.
//   Emits one mixed 16-bit PCM sample per sample tick, which drives dac.pcm.
//   CPU/button logic configures each voice through a valid/ready write port.
// PARAMETERS
//   NUM_VOICES  4    number of voices; power of 2, range 2..16
//   SAMPLE_DIV  256  clk cycles per sample tick; nominal >= NUM_VOICES+2
// PORTS
//   clk        in   1   system clock
//   rst_n      in   1   asynchronous active-low reset
//   cfg_valid  in   1   config write request
//   cfg_ready  out  1   config write accepted when cfg_valid & cfg_ready
//   cfg_voice  in   log2(NUM_VOICES)  target voice index
//   cfg_sel    in   1   0 = phase increment; 1 = {enable, volume}
//   cfg_wdata  in   16  sel=0: inc[15:0]; sel=1: [8]=enable, [7:0]=volume
//   pcm        out  16  mixed sample, held between updates
//   pcm_valid  out  1   one-cycle pulse when pcm updates
//   busy       out  1   high in ACCUM and OUTPUT
//   overrun    out  1   sticky; set when a tick arrives while busy
// BEHAVIOUR
//   Reset: pcm=0, pcm_valid=0, busy=0, overrun=0, cfg_ready=1, state=IDLE.
//     All inc/phase/vol/enable=0; prescaler=0; acc=0; idx=0.
//   Prescaler: counts 0..SAMPLE_DIV-1 and wraps. tick=1 for one cycle at count SAMPLE_DIV-1.
//     First tick occurs in cycle SAMPLE_DIV after reset release.
//   FSM IDLE: cfg_ready=1. tick -> ACCUM with idx=0, acc=0.
//   FSM ACCUM: one voice per cycle, idx = 0..NUM_VOICES-1.
//     enabled:  contrib = (phase[idx]*vol[idx])>>8, 16 bit; phase[idx] <= phase[idx]+inc[idx] mod 2^16.
//     disabled: contrib = 0; phase holds.
//     acc += contrib; acc is 16+log2(NUM_VOICES) bits and cannot overflow.
//     After idx = NUM_VOICES-1 -> OUTPUT.
//   FSM OUTPUT: pcm <= acc >> log2(NUM_VOICES); pcm_valid=1 for this cycle; -> IDLE.
//   Latency: tick to pcm_valid = NUM_VOICES+1 cycles.
//     Each sample uses the pre-increment phase (the first sample after enable is 0).
//   Config: cfg_ready=0 whenever state != IDLE; a request waits, held by the requester.
//     A write accepted in IDLE takes effect from the next ACCUM.
//     sel=1 with enable=0 also clears phase[voice] to 0.
//     sel=1 with enable=1 on an already-enabled voice keeps its phase.
//   Simultaneous tick and accepted write in IDLE: the write commits; ACCUM starts
//     the next cycle and sees the new value.
//   Tick while busy: the tick is dropped, overrun <= 1 (cleared only by reset),
//     and the current sample completes normally.
//   Reset mid-ACCUM/OUTPUT: aborts immediately with no pcm_valid; all state returns to reset values.
// TESTING
//   1 NUM_VOICES=4. Voice0 inc=0x4000, vol=0x80, en=1; others disabled.
//     -> successive pcm 0x0000,0x0800,0x1000,0x1800,0x0000 (phase wrap).
//   2 All 4 voices inc=0x4000, vol=0xFF, en=1 -> 4th sample pcm=0xBF40.
//     Also check pcm_valid arrives 5 cycles after tick.
//   3 Hold cfg_valid during ACCUM -> cfg_ready stays 0 until the cycle after pcm_valid.
//     The write accepts then; the new inc is visible in the next sample only.
//   4 SAMPLE_DIV=4, NUM_VOICES=4 -> overrun=1 after the second tick and stays 1.
//     pcm_valid pulses only for samples that start from IDLE.
//   5 Drop rst_n during ACCUM idx=2 -> no pcm_valid; pcm=0, overrun=0, all phases 0
//     after release; the first tick lands at cycle SAMPLE_DIV.
//   6 Voice0 running at phase 0x8000; write sel=1 wdata=0x0080 (en=0) -> contributes 0.
//     Re-enable: the next sample's contribution is 0, then ramps from inc.

Source files
------------

// File: rtl/voice_scheduler.sv
// Time-multiplexed sawtooth voice mixer: one shared phase adder and multiplier
// walk every voice once per sample tick and emit the averaged 16-bit PCM sample.
module voice_scheduler #(
  parameter int NUM_VOICES = 4,
  parameter int SAMPLE_DIV = 256,
  localparam int IW = $clog2(NUM_VOICES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [IW-1:0] cfg_voice,
  input  logic          cfg_sel,
  input  logic [15:0]   cfg_wdata,
  output logic [15:0]   pcm,
  output logic          pcm_valid,
  output logic          busy,
  output logic          overrun
);

  localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int AW = 16 + IW;

  typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [AW-1:0]         acc_q, acc_d, acc_sum;
  logic [15:0]           pcm_q, pcm_d;
  logic                  pcm_valid_q, pcm_valid_d;
  logic                  overrun_q, overrun_d;
  logic [15:0]           inc_q   [NUM_VOICES];
  logic [15:0]           inc_d   [NUM_VOICES];
  logic [15:0]           phase_q [NUM_VOICES];
  logic [15:0]           phase_d [NUM_VOICES];
  logic [7:0]            vol_q   [NUM_VOICES];
  logic [7:0]            vol_d   [NUM_VOICES];
  logic [NUM_VOICES-1:0] en_q, en_d;

  logic        tick;
  logic        cfg_fire;
  logic [23:0] prod;
  logic [15:0] contrib;

  always_comb begin
    tick     = (cnt_q == CW'(SAMPLE_DIV - 1));
    cnt_d    = tick ? '0 : cnt_q + CW'(1);
    cfg_fire = cfg_valid && (state_q == IDLE);

    // Shared datapath: the voice selected by idx_q this cycle.
    prod    = 24'(phase_q[idx_q]) * 24'(vol_q[idx_q]);
    contrib = en_q[idx_q] ? 16'(prod >> 8) : 16'h0000;
    acc_sum = acc_q + AW'(contrib);

    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    pcm_d       = pcm_q;
    pcm_valid_d = 1'b0;
    overrun_d   = overrun_q | (tick && (state_q != IDLE));
    inc_d       = inc_q;
    phase_d     = phase_q;
    vol_d       = vol_q;
    en_d        = en_q;

    case (state_q)
      IDLE: begin
        if (cfg_fire) begin
          if (!cfg_sel) begin
            inc_d[cfg_voice] = cfg_wdata;
          end else begin
            en_d[cfg_voice]  = cfg_wdata[8];
            vol_d[cfg_voice] = cfg_wdata[7:0];
            if (!cfg_wdata[8]) phase_d[cfg_voice] = 16'h0000;
          end
        end
        if (tick) begin
          state_d = ACCUM;
          idx_d   = '0;
          acc_d   = '0;
        end
      end
      ACCUM: begin
        acc_d = acc_sum;
        if (en_q[idx_q]) phase_d[idx_q] = phase_q[idx_q] + inc_q[idx_q];
        idx_d = idx_q + IW'(1);
        // Publish on the last voice so pcm and pcm_valid appear together in OUTPUT.
        if (idx_q == IW'(NUM_VOICES - 1)) begin
          state_d     = OUTPUT;
          pcm_d       = 16'(acc_sum >> IW);
          pcm_valid_d = 1'b1;
        end
      end
      OUTPUT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      pcm_q       <= '0;
      pcm_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      inc_q       <= '{default: '0};
      phase_q     <= '{default: '0};
      vol_q       <= '{default: '0};
      en_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      pcm_q       <= pcm_d;
      pcm_valid_q <= pcm_valid_d;
      overrun_q   <= overrun_d;
      inc_q       <= inc_d;
      phase_q     <= phase_d;
      vol_q       <= vol_d;
      en_q        <= en_d;
    end
  end

  assign pcm       = pcm_q;
  assign pcm_valid = pcm_valid_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE);
  assign cfg_ready = (state_q == IDLE);

endmodule

// File: tb/tb_voice_scheduler.sv
// Randomized scoreboard bench for voice_scheduler, plus a fast-tick instance
// exercising the overrun path.
module tb_voice_scheduler;

  localparam int N   = 4;
  localparam int SD  = 16;
  localparam int SD4 = 4;
  localparam int OVR_FIRST  = SD4 + N + 1;
  localparam int OVR_PERIOD = 2 * SD4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_voice;
  logic        cfg_sel;
  logic [15:0] cfg_wdata;
  logic [15:0] pcm;
  logic        pcm_valid;
  logic        busy;
  logic        overrun;

  logic        cfg_valid4;
  logic        cfg_ready4;
  logic [1:0]  cfg_voice4;
  logic        cfg_sel4;
  logic [15:0] cfg_wdata4;
  logic [15:0] pcm4;
  logic        pcm_valid4;
  logic        busy4;
  logic        overrun4;

  int checks = 0;
  int errors = 0;
  int cyc;

  always #5 clk = ~clk;

  voice_scheduler #(.NUM_VOICES(N), .SAMPLE_DIV(SD)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_voice(cfg_voice), .cfg_sel(cfg_sel), .cfg_wdata(cfg_wdata),
    .pcm(pcm), .pcm_valid(pcm_valid), .busy(busy), .overrun(overrun)
  );

  voice_scheduler #(.NUM_VOICES(N), .SAMPLE_DIV(SD4)) dut4 (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid4), .cfg_ready(cfg_ready4),
    .cfg_voice(cfg_voice4), .cfg_sel(cfg_sel4), .cfg_wdata(cfg_wdata4),
    .pcm(pcm4), .pcm_valid(pcm_valid4), .busy(busy4), .overrun(overrun4)
  );

  // Cycle number since reset release; cycle 1 is the first cycle after release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 1;
    else        cyc <= cyc + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h cycle=%0d", name, actual, expected, cyc);
    end
  endtask

  typedef struct {
    logic [15:0] pcm;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned m_inc[N];
  int unsigned m_phase[N];
  int unsigned m_vol[N];
  bit          m_en[N];
  int          m_pc;
  int          m_busy_left;
  bit          m_overrun;

  // Reference model: per-voice registers, a prescaler and a busy window, all
  // advanced once per cycle. A whole sample is computed at the tick.
  always @(negedge clk) begin : model
    bit          m_busy;
    bit          m_tick;
    int unsigned sum;
    if (!rst_n) begin
      for (int v = 0; v < N; v++) begin
        m_inc[v] = 0; m_phase[v] = 0; m_vol[v] = 0; m_en[v] = 0;
      end
      m_pc = 0;
      m_busy_left = 0;
      m_overrun = 0;
      exp_q.delete();
    end else begin
      m_busy = (m_busy_left > 0);
      checkOutput("cfg_ready", {31'b0, cfg_ready}, {31'b0, !m_busy});
      checkOutput("busy", {31'b0, busy}, {31'b0, m_busy});
      checkOutput("overrun", {31'b0, overrun}, {31'b0, m_overrun});
      if (cfg_valid && !m_busy) begin
        if (!cfg_sel) begin
          m_inc[cfg_voice] = cfg_wdata;
        end else begin
          m_en[cfg_voice]  = cfg_wdata[8];
          m_vol[cfg_voice] = cfg_wdata[7:0];
          if (!cfg_wdata[8]) m_phase[cfg_voice] = 0;
        end
      end
      m_tick = (m_pc == SD - 1);
      m_pc = (m_pc + 1) % SD;
      if (m_tick && m_busy) m_overrun = 1;
      if (m_tick && !m_busy) begin
        sum = 0;
        for (int v = 0; v < N; v++) begin
          if (m_en[v]) begin
            sum += (m_phase[v] * m_vol[v]) >> 8;
            m_phase[v] = (m_phase[v] + m_inc[v]) % 65536;
          end
        end
        exp_q.push_back('{pcm: 16'(sum / N), due: cyc + N + 1});
        m_busy_left = N + 1;
      end else if (m_busy_left > 0) begin
        m_busy_left--;
      end
    end
  end

  logic [15:0] last_pcm;

  // Monitor: pops one expected sample per pcm_valid and checks value and arrival cycle.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst_n) begin
      last_pcm = 16'h0000;
    end else begin
      if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        checks++;
        errors++;
        $display("[TB] FAIL missed_pcm_valid actual=none expected_cycle=%0d cycle=%0d", exp_q[0].due, cyc);
        void'(exp_q.pop_front());
      end
      if (pcm_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_pcm_valid actual=0x%0h expected=none cycle=%0d", pcm, cyc);
        end else begin
          e = exp_q.pop_front();
          checkOutput("pcm_value", {16'b0, pcm}, {16'b0, e.pcm});
          checkOutput("pcm_latency_cycle", cyc, e.due);
          last_pcm = e.pcm;
        end
      end else begin
        checkOutput("pcm_hold", {16'b0, pcm}, {16'b0, last_pcm});
      end
    end
  end

  // Fast-tick instance: every second tick lands while busy and is dropped.
  always @(negedge clk) begin : ovr_check
    if (!rst_n) begin
      checkOutput("ovr_reset_overrun", {31'b0, overrun4}, 32'd0);
      checkOutput("ovr_reset_valid", {31'b0, pcm_valid4}, 32'd0);
    end else begin
      checkOutput("ovr_overrun", {31'b0, overrun4}, {31'b0, cyc >= OVR_FIRST});
      checkOutput("ovr_pcm_valid", {31'b0, pcm_valid4},
                  {31'b0, (cyc >= OVR_FIRST) && ((cyc - OVR_FIRST) % OVR_PERIOD == 0)});
      checkOutput("ovr_pcm", {16'b0, pcm4}, 32'd0);
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int voice, input bit sel, input logic [15:0] data);
    int waited = 0;
    bit accepted = 0;
    cfg_voice = 2'(voice);
    cfg_sel   = sel;
    cfg_wdata = data;
    cfg_valid = 1'b1;
    while (!accepted && waited < 64) begin
      @(negedge clk);
      accepted = cfg_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    cfg_valid = 1'b0;
    if (!accepted) begin
      checks++;
      errors++;
      $display("[TB] FAIL cfg_accept_timeout actual=not_accepted expected=accepted cycle=%0d", cyc);
    end
  endtask

  task automatic waitSample(output logic [15:0] v, output int at_cyc);
    int n = 0;
    bit got = 0;
    v = '0;
    at_cyc = -1;
    while (!got && n < 4 * SD) begin
      @(negedge clk);
      if (pcm_valid) begin
        got = 1;
        v = pcm;
        at_cyc = cyc;
      end
      n++;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL sample_timeout actual=none expected=pcm_valid cycle=%0d", cyc);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    waitCycles(3);
    rst_n = 1'b1;
    checkOutput("reset_pcm", {16'b0, pcm}, 32'd0);
    checkOutput("reset_pcm_valid", {31'b0, pcm_valid}, 32'd0);
    checkOutput("reset_busy", {31'b0, busy}, 32'd0);
    checkOutput("reset_overrun", {31'b0, overrun}, 32'd0);
    checkOutput("reset_cfg_ready", {31'b0, cfg_ready}, 32'd1);
  endtask

  task automatic waitPhase(input int offset);
    while (!(cyc > SD && (cyc % SD) == offset)) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin : watchdog
    #(60000 * 10);
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic [15:0] s;
    logic [15:0] exp1[5];
    logic [15:0] exp2[4];
    int          at;
    int          voice;
    bit          sel;
    logic [15:0] data;

    exp1 = '{16'h0000, 16'h0800, 16'h1000, 16'h1800, 16'h0000};
    exp2 = '{16'h0000, 16'h3FC0, 16'h7F80, 16'hBF40};
    rst_n = 1'b0;
    cfg_valid = 1'b0; cfg_voice = '0; cfg_sel = 1'b0; cfg_wdata = '0;
    cfg_valid4 = 1'b0; cfg_voice4 = '0; cfg_sel4 = 1'b0; cfg_wdata4 = '0;
    @(posedge clk);
    #1;
    doReset();

    $display("[TB] single voice sawtooth");
    applyStimulus(0, 0, 16'h4000);
    applyStimulus(0, 1, 16'h0180);
    for (int i = 0; i < 5; i++) begin
      waitSample(s, at);
      checkOutput("single_voice_seq", {16'b0, s}, {16'b0, exp1[i]});
    end

    $display("[TB] four voices full volume");
    doReset();
    for (int v = 0; v < N; v++) applyStimulus(v, 0, 16'h4000);
    for (int v = 0; v < N; v++) applyStimulus(v, 1, 16'h01FF);
    for (int i = 0; i < 4; i++) begin
      waitSample(s, at);
      checkOutput("four_voice_seq", {16'b0, s}, {16'b0, exp2[i]});
    end

    $display("[TB] write held during accumulate");
    waitPhase(1);
    applyStimulus(1, 0, 16'h1000);
    waitCycles(3 * SD);

    $display("[TB] disable and re-enable");
    doReset();
    applyStimulus(0, 0, 16'h4000);
    applyStimulus(0, 1, 16'h0180);
    waitSample(s, at);
    waitSample(s, at);
    applyStimulus(0, 1, 16'h0080);
    waitSample(s, at);
    checkOutput("disabled_contrib", {16'b0, s}, 32'd0);
    applyStimulus(0, 1, 16'h0180);
    waitSample(s, at);
    checkOutput("reenable_first", {16'b0, s}, 32'd0);
    waitSample(s, at);
    checkOutput("reenable_ramp", {16'b0, s}, 32'h0800);

    $display("[TB] reset during accumulate");
    waitPhase(3);
    rst_n = 1'b0;
    waitCycles(2);
    rst_n = 1'b1;
    checkOutput("abort_pcm", {16'b0, pcm}, 32'd0);
    checkOutput("abort_overrun", {31'b0, overrun}, 32'd0);
    waitSample(s, at);
    checkOutput("abort_first_sample_cycle", at, SD + N + 1);
    checkOutput("abort_first_sample", {16'b0, s}, 32'd0);

    $display("[TB] randomized configuration");
    for (int i = 0; i < 40; i++) begin
      waitCycles($urandom_range(0, 12));
      voice = $urandom_range(0, N - 1);
      sel   = 1'($urandom_range(0, 1));
      data  = sel ? {7'b0, 1'($urandom_range(0, 3) != 0), 8'($urandom)} : 16'($urandom);
      applyStimulus(voice, sel, data);
    end
    waitCycles(3 * SD);
    checkOutput("queue_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
